// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, data_be, mem_ready, mem_rdata,
    output fetch_ack, fetch_rdata, fetch_err, data_ack, data_rdata, data_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, data_be, mem_ready, mem_rdata,
    input  fetch_ack, fetch_rdata, fetch_err, data_ack, data_rdata, data_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int DBURSTMAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int WW = $clog2(TIMEOUT);
  localparam int SW = $clog2(DBURSTMAX + 1);
  state_t state, state_n;
  logic gnt_d, gnt_d_n, pick_d, tmo;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [SW-1:0] streak, streak_n;
  logic m_req_n, m_we_n, f_ack_n, f_err_n, d_ack_n, d_err_n;
  logic [31:0] m_addr_n, m_wdata_n, f_rdata_n, d_rdata_n;
  logic [3:0] m_be_n;
  always_comb begin
    pick_d = bus.data_req && !(bus.fetch_req && streak == SW'(DBURSTMAX));
    tmo = wait_cnt == WW'(TIMEOUT - 1);
    state_n = state;
    gnt_d_n = gnt_d;
    wait_n = wait_cnt;
    streak_n = streak;
    m_req_n = bus.mem_req;
    m_we_n = bus.mem_we;
    m_addr_n = bus.mem_addr;
    m_wdata_n = bus.mem_wdata;
    m_be_n = bus.mem_be;
    f_ack_n = 1'b0;
    f_err_n = 1'b0;
    d_ack_n = 1'b0;
    d_err_n = 1'b0;
    f_rdata_n = bus.fetch_rdata;
    d_rdata_n = bus.data_rdata;
    case (state)
      IDLE: begin
        streak_n = (pick_d && bus.fetch_req) ? streak + SW'(1) : '0;
        if (bus.fetch_req || bus.data_req) begin
          gnt_d_n = pick_d;
          m_we_n = pick_d && bus.data_we;
          m_addr_n = pick_d ? bus.data_addr : bus.fetch_addr;
          m_wdata_n = pick_d ? bus.data_wdata : '0;
          m_be_n = pick_d ? bus.data_be : 4'b1111;
          wait_n = '0;
          // a store with no enabled lanes is misaligned and never reaches memory
          if (pick_d && bus.data_we && bus.data_be == 4'b0000) begin
            state_n = RESP;
            d_ack_n = 1'b1;
            d_err_n = 1'b1;
          end else begin
            state_n = BUSY;
            m_req_n = 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready || tmo) begin
          state_n = RESP;
          m_req_n = 1'b0;
          f_ack_n = !gnt_d;
          d_ack_n = gnt_d;
          f_err_n = !gnt_d && !bus.mem_ready;
          d_err_n = gnt_d && !bus.mem_ready;
          f_rdata_n = gnt_d ? bus.fetch_rdata : (bus.mem_ready ? bus.mem_rdata : '0);
          d_rdata_n = gnt_d ? (bus.mem_ready ? bus.mem_rdata : '0) : bus.data_rdata;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_d <= 1'b0;
      wait_cnt <= '0;
      streak <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be <= '0;
      bus.fetch_ack <= 1'b0;
      bus.fetch_err <= 1'b0;
      bus.fetch_rdata <= '0;
      bus.data_ack <= 1'b0;
      bus.data_err <= 1'b0;
      bus.data_rdata <= '0;
    end else begin
      state <= state_n;
      gnt_d <= gnt_d_n;
      wait_cnt <= wait_n;
      streak <= streak_n;
      bus.mem_req <= m_req_n;
      bus.mem_we <= m_we_n;
      bus.mem_addr <= m_addr_n;
      bus.mem_wdata <= m_wdata_n;
      bus.mem_be <= m_be_n;
      bus.fetch_ack <= f_ack_n;
      bus.fetch_err <= f_err_n;
      bus.fetch_rdata <= f_rdata_n;
      bus.data_ack <= d_ack_n;
      bus.data_err <= d_err_n;
      bus.data_rdata <= d_rdata_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared memory port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT(16), .DBURSTMAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
    logic        chk;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  logic mem_on = 1'b1;
  int mem_lat = 0;
  int busy_cnt = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  // memory model: answers mem_lat cycles after mem_req is first seen
  always @(negedge clk) begin
    if (bus.mem_req && mem_on && busy_cnt == mem_lat) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem_word(bus.mem_addr);
      busy_cnt = 0;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0BAD0BAD;
      busy_cnt = bus.mem_req ? busy_cnt + 1 : 0;
    end
  end
  always @(negedge clk) begin
    if (!rst && (bus.fetch_ack || bus.data_ack)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: fetch_ack=%b data_ack=%b, required no ack", bus.fetch_ack, bus.data_ack);
      end else begin
        e = sb.pop_front();
        if ({bus.data_ack, bus.fetch_ack} !== {e.is_d, !e.is_d}) begin
          fails++;
          $display("FAIL ack_port: data_ack,fetch_ack=%b%b, required %b%b", bus.data_ack, bus.fetch_ack, e.is_d, !e.is_d);
        end
        tests++;
        if ((e.is_d ? bus.data_err : bus.fetch_err) !== e.err) begin
          fails++;
          $display("FAIL ack_err: got %b, required %b", e.is_d ? bus.data_err : bus.fetch_err, e.err);
        end
        if (e.chk) begin
          tests++;
          if ((e.is_d ? bus.data_rdata : bus.fetch_rdata) !== e.data) begin
            fails++;
            $display("FAIL ack_rdata: got %h, required %h", e.is_d ? bus.data_rdata : bus.fetch_rdata, e.data);
          end
        end
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({bus.fetch_ack, bus.fetch_err, bus.data_ack, bus.data_err, bus.mem_req, bus.mem_we, bus.mem_be,
         bus.mem_addr, bus.mem_wdata, bus.fetch_rdata, bus.data_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: mem_req=%b acks=%b%b addr=%h, required all zero",
               bus.mem_req, bus.fetch_ack, bus.data_ack, bus.mem_addr);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_single_load();
    mem_lat = 0;
    sb.push_back(exp_t'{1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h100; bus.data_wdata = '0; bus.data_be = 4'b1111;
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
      fails++;
      $display("FAIL load_cmd: req=%b we=%b be=%b addr=%h, required 1 0 1111 00000100",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
    end
    tick();
    tests++;
    if (bus.data_ack !== 1'b1) begin
      fails++;
      $display("FAIL load_latency: data_ack=%b, required 1", bus.data_ack);
    end
    bus.data_req = 1'b0;
    tick();
  endtask
  task automatic test_misaligned();
    int hi = 0;
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b1, 1'b0});
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h204; bus.data_wdata = 32'h11223344; bus.data_be = 4'b0000;
    tick();
    tests++;
    if ({bus.data_ack, bus.data_err, bus.mem_req} !== 3'b110) begin
      fails++;
      $display("FAIL misaligned_resp: ack,err,mem_req=%b%b%b, required 110", bus.data_ack, bus.data_err, bus.mem_req);
    end
    bus.data_req = 1'b0;
    repeat (3) begin
      tick();
      if (bus.mem_req) hi++;
    end
    tests++;
    if (hi !== 0) begin
      fails++;
      $display("FAIL misaligned_no_mem: mem_req cycles=%0d, required 0", hi);
    end
  endtask
  task automatic test_back_to_back();
    int nd = 0, ni = 0, cyc = 0, last = 0;
    mem_lat = 0;
    for (int i = 0; i < 6; i++)
      sb.push_back(i == 4 ? exp_t'{1'b0, mem_word(32'h400), 1'b0, 1'b1} : exp_t'{1'b1, mem_word(32'h300), 1'b0, 1'b1});
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h300; bus.data_be = 4'b1111;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h400;
    while ((nd < 5 || ni < 1) && cyc < 60) begin
      tick();
      cyc++;
      if (bus.data_ack) begin nd++; last = cyc; if (nd == 5) bus.data_req = 1'b0; end
      if (bus.fetch_ack) begin ni++; last = cyc; bus.fetch_req = 1'b0; end
    end
    bus.data_req = 1'b0; bus.fetch_req = 1'b0;
    tests++;
    if (nd !== 5 || ni !== 1) begin
      fails++;
      $display("FAIL burst_acks: data=%0d fetch=%0d, required 5 and 1", nd, ni);
    end
    tests++;
    if (last !== 17) begin
      fails++;
      $display("FAIL burst_throughput: last ack at cycle %0d, required 17", last);
    end
    tick();
  endtask
  task automatic test_timeout();
    int hi = 0, cyc = 0;
    logic got = 1'b0;
    mem_on = 1'b0;
    sb.push_back(exp_t'{1'b0, 32'h0, 1'b1, 1'b1});
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h500;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (bus.mem_req) hi++;
      if (bus.fetch_ack) got = 1'b1;
    end
    bus.fetch_req = 1'b0;
    mem_on = 1'b1;
    tests++;
    if (hi !== 16) begin
      fails++;
      $display("FAIL timeout_req_cycles: %0d, required 16", hi);
    end
    tests++;
    if (cyc !== 17) begin
      fails++;
      $display("FAIL timeout_ack_cycle: %0d, required 17", cyc);
    end
    tick();
  endtask
  task automatic test_store_half();
    int hi = 0, cyc = 0;
    logic got = 1'b0;
    mem_lat = 3;
    sb.push_back(exp_t'{1'b1, mem_word(32'h600), 1'b0, 1'b1});
    bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h600; bus.data_wdata = 32'hABCDABCD; bus.data_be = 4'b1100;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (bus.data_ack) got = 1'b1;
      if (bus.mem_req) begin
        hi++;
        tests++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'b1100, 32'h600, 32'hABCDABCD}) begin
          fails++;
          $display("FAIL store_cmd: we=%b be=%b addr=%h wdata=%h, required 1 1100 00000600 abcdabcd",
                   bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
      end
    end
    bus.data_req = 1'b0;
    mem_lat = 0;
    tests++;
    if (hi !== 4 || !got) begin
      fails++;
      $display("FAIL store_hold: mem_req cycles=%0d ack=%b, required 4 and 1", hi, got);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    int acks = 0;
    mem_on = 1'b0;
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h700; bus.data_be = 4'b1111;
    repeat (3) tick();
    tests++;
    if (bus.mem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: mem_req=%b, required 1", bus.mem_req);
    end
    rst = 1'b1;
    bus.data_req = 1'b0;
    tick();
    tests++;
    if ({bus.mem_req, bus.data_ack, bus.fetch_ack} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_abort: mem_req,data_ack,fetch_ack=%b%b%b, required 000",
               bus.mem_req, bus.data_ack, bus.fetch_ack);
    end
    rst = 1'b0;
    mem_on = 1'b1;
    repeat (4) begin
      tick();
      if (bus.data_ack || bus.fetch_ack) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_ack: %0d acks, required 0", acks);
    end
    sb.push_back(exp_t'{1'b0, mem_word(32'h800), 1'b0, 1'b1});
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h800;
    tick();
    tick();
    tests++;
    if (bus.fetch_ack !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_recover: fetch_ack=%b, required 1", bus.fetch_ack);
    end
    bus.fetch_req = 1'b0;
    tick();
  endtask
  initial begin
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0; bus.data_be = '0;
    test_reset();
    test_single_load();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_store_half();
    test_reset_mid();
    repeat (3) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d acks outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
